// File: rtl/shift_seq_unit.sv
// ============================================================================
// shift_seq_unit : sequenced universal shift register (load, then AMT shifts)
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_seq_mux4 (
  input  logic       j0_i,
  input  logic       j1_i,
  input  logic [0:3] in_i,
  output logic       y_o
);
  // j0 is the select MSB, so {j0,j1} = {m[1],m[0]} indexes {hold,right,left,load}
  assign y_o = in_i[{j0_i, j1_i}];
endmodule

module shift_seq_unit #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [CNTW-1:0]  amt_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             sin_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             sout_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_SHIFT = 2'd1;
  localparam logic [1:0] c_ST_DONE  = 2'd2;

  localparam logic [1:0] c_OP_ROR = 2'b00;
  localparam logic [1:0] c_OP_LSR = 2'b01;
  localparam logic [1:0] c_OP_LSL = 2'b10;
  localparam logic [1:0] c_OP_ASR = 2'b11;

  localparam logic [1:0] c_M_HOLD  = 2'b00;
  localparam logic [1:0] c_M_RIGHT = 2'b01;
  localparam logic [1:0] c_M_LEFT  = 2'b10;
  localparam logic [1:0] c_M_LOAD  = 2'b11;

  logic [1:0]       state_q, state_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [1:0]       w_mode;
  logic             w_fill_r;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    w_mode  = c_M_HOLD;
    case (state_q)
      c_ST_IDLE: begin
        if (start_i) begin
          w_mode  = c_M_LOAD;
          op_d    = op_i;
          cnt_d   = amt_i;
          state_d = (amt_i == '0) ? c_ST_DONE : c_ST_SHIFT;
        end
      end
      c_ST_SHIFT: begin
        w_mode = (op_q == c_OP_LSL) ? c_M_LEFT : c_M_RIGHT;
        cnt_d  = cnt_q - CNTW'(1);
        if (cnt_q == CNTW'(1)) begin
          state_d = c_ST_DONE;
        end
      end
      c_ST_DONE: begin
        state_d = c_ST_IDLE;
      end
      default: begin
        state_d = c_ST_IDLE;
      end
    endcase
  end

  // MSB fill for right-moving ops; the left op never selects this path
  always_comb begin
    w_fill_r = sin_i;
    case (op_q)
      c_OP_ROR: w_fill_r = dout_q[0];
      c_OP_LSR: w_fill_r = sin_i;
      c_OP_ASR: w_fill_r = dout_q[WIDTH-1];
      default:  w_fill_r = sin_i;
    endcase
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    logic w_right;
    logic w_left;
    if (gi == WIDTH-1) begin : g_right_edge
      assign w_right = w_fill_r;
    end else begin : g_right_inner
      assign w_right = dout_q[gi+1];
    end
    if (gi == 0) begin : g_left_edge
      assign w_left = sin_i;
    end else begin : g_left_inner
      assign w_left = dout_q[gi-1];
    end
    shift_seq_mux4 u_cell (
      .j0_i (w_mode[1]),
      .j1_i (w_mode[0]),
      .in_i ({dout_q[gi], w_right, w_left, din_i[gi]}),
      .y_o  (dout_d[gi])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= c_ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      dout_q  <= dout_d;
    end
  end

  assign dout_o = dout_q;
  assign sout_o = (op_q == c_OP_LSL) ? dout_q[WIDTH-1] : dout_q[0];
  assign busy_o = (state_q == c_ST_SHIFT);
  assign done_o = (state_q == c_ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_shift_seq_unit.sv
// ============================================================================
// tb_shift_seq_unit : directed + randomized bench with arithmetic reference model
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_seq_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_i;
  logic [1:0] op_i;
  logic [3:0] amt_i;
  logic [7:0] din_i;
  logic       sin_i;
  logic [7:0] dout_o;
  logic       sout_o;
  logic       busy_o;
  logic       done_o;

  int checks = 0;
  int errors = 0;

  shift_seq_unit #(.WIDTH(8), .CNTW(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .start_i (start_i),
    .op_i    (op_i),
    .amt_i   (amt_i),
    .din_i   (din_i),
    .sin_i   (sin_i),
    .dout_o  (dout_o),
    .sout_o  (sout_o),
    .busy_o  (busy_o),
    .done_o  (done_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One shift step expressed arithmetically
  function automatic logic [7:0] model_shift(input logic [7:0] v, input logic [1:0] op,
                                             input logic s);
    logic [7:0] sv;
    sv = {7'd0, s};
    case (op)
      2'b00:   return (v >> 1) | (v << 7);
      2'b01:   return (v >> 1) | (sv << 7);
      2'b10:   return (v << 1) | sv;
      default: return 8'($signed(v) >>> 1);
    endcase
  endfunction

  function automatic logic model_sout(input logic [7:0] v, input logic [1:0] op);
    return (op == 2'b10) ? v[7] : v[0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one transaction starting from IDLE; returns final model value
  task automatic run_txn(input string tag, input logic [7:0] d, input logic [1:0] o,
                         input logic [3:0] a, input logic s_fix, input bit rand_sin,
                         input bit poke_start, output logic [7:0] result);
    logic [7:0] m;
    logic       s;
    m = d;
    din_i = d; op_i = o; amt_i = a; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    din_i = 8'($urandom); op_i = 2'($urandom); amt_i = 4'($urandom);
    for (int k = 0; k < int'(a); k++) begin
      chk({tag, " busy"}, 32'(busy_o), 32'd1);
      chk({tag, " done_in_shift"}, 32'(done_o), 32'd0);
      chk({tag, " dout_mid"}, 32'(dout_o), 32'(m));
      chk({tag, " sout"}, 32'(sout_o), 32'(model_sout(m, o)));
      s = rand_sin ? 1'($urandom) : s_fix;
      sin_i = s;
      if (poke_start && k == 0) start_i = 1'b1;
      tick();
      start_i = 1'b0;
      m = model_shift(m, o, s);
    end
    chk({tag, " busy_at_done"}, 32'(busy_o), 32'd0);
    chk({tag, " done"}, 32'(done_o), 32'd1);
    chk({tag, " dout"}, 32'(dout_o), 32'(m));
    if (poke_start) start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk({tag, " done_pulse_end"}, 32'(done_o), 32'd0);
    chk({tag, " idle_busy"}, 32'(busy_o), 32'd0);
    chk({tag, " dout_hold"}, 32'(dout_o), 32'(m));
    result = m;
  endtask

  initial begin
    logic [7:0] r;
    logic [7:0] rd;
    logic [1:0] ro;
    logic [3:0] ra;
    logic       rs;
    bit         saw_done;

    reset = 1'b1; start_i = 1'b1; op_i = 2'b01; amt_i = 4'd3; din_i = 8'hFF; sin_i = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("reset dout", 32'(dout_o), 32'h00);
      chk("reset busy", 32'(busy_o), 32'd0);
      chk("reset done", 32'(done_o), 32'd0);
    end
    reset = 1'b0; start_i = 1'b0;
    tick();
    chk("post_reset dout", 32'(dout_o), 32'h00);

    run_txn("lsr3", 8'hB4, 2'b01, 4'd3, 1'b0, 1'b0, 1'b0, r);
    chk("lsr3 const", 32'(r), 32'h16);
    run_txn("ror1", 8'h81, 2'b00, 4'd1, 1'b0, 1'b0, 1'b0, r);
    chk("ror1 const", 32'(r), 32'hC0);
    run_txn("ror8", 8'h81, 2'b00, 4'd8, 1'b0, 1'b0, 1'b0, r);
    chk("ror8 const", 32'(r), 32'h81);
    run_txn("asr2", 8'h90, 2'b11, 4'd2, 1'b0, 1'b0, 1'b0, r);
    chk("asr2 const", 32'(r), 32'hE4);
    run_txn("lsl4", 8'h01, 2'b10, 4'd4, 1'b1, 1'b0, 1'b0, r);
    chk("lsl4 const", 32'(r), 32'h1F);
    run_txn("amt0", 8'h5A, 2'b01, 4'd0, 1'b0, 1'b0, 1'b0, r);
    chk("amt0 const", 32'(r), 32'h5A);
    run_txn("poke", 8'hC3, 2'b01, 4'd5, 1'b1, 1'b0, 1'b1, r);
    chk("poke const", 32'(r), 32'hFE);
    run_txn("ror15", 8'h2D, 2'b00, 4'd15, 1'b0, 1'b0, 1'b0, r);
    chk("ror15 const", 32'(r), 32'h5A);

    // Abort mid-shift: no done pulse may follow
    din_i = 8'hA5; op_i = 2'b00; amt_i = 4'd10; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick(); tick();
    chk("abort busy_before", 32'(busy_o), 32'd1);
    reset = 1'b1;
    tick();
    chk("abort dout", 32'(dout_o), 32'h00);
    chk("abort busy", 32'(busy_o), 32'd0);
    chk("abort done", 32'(done_o), 32'd0);
    reset = 1'b0;
    saw_done = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (done_o !== 1'b0 || busy_o !== 1'b0) saw_done = 1'b1;
    end
    chk("abort no_done", 32'(saw_done), 32'd0);
    chk("abort dout_after", 32'(dout_o), 32'h00);

    for (int n = 0; n < 40; n++) begin
      rd = 8'($urandom); ro = 2'($urandom); ra = 4'($urandom); rs = 1'($urandom);
      run_txn($sformatf("rand%0d", n), rd, ro, ra, rs, 1'b1, (n % 5) == 0, r);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
